duart_channel: RTL and testbench



---
 rtl/duart_pkg.sv | 31 +++
 rtl/duart_rx_fifo.sv | 63 ++++++
 rtl/uart_rx.sv | 74 +++++++
 rtl/uart_tx.sv | 55 +++++
 rtl/duart_channel.sv | 192 +++++++++++++++++++
 tb/tb_duart_channel.sv | 283 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/duart_pkg.sv
// duart_pkg: shared constants for the DUART serial channel.
//   Register addresses, status-register bit positions, command-register
//   encodings and the transmit launch state type.
package duart_pkg;

  localparam logic [1:0] ADDR_MR  = 2'd0;
  localparam logic [1:0] ADDR_SR  = 2'd1;
  localparam logic [1:0] ADDR_CR  = 2'd2;
  localparam logic [1:0] ADDR_RHR = 2'd3;

  localparam int SR_RXRDY   = 0;
  localparam int SR_FFULL   = 1;
  localparam int SR_TXRDY   = 2;
  localparam int SR_TXEMT   = 3;
  localparam int SR_OVERRUN = 4;

  localparam logic [1:0] CR_EN_SET = 2'b01;
  localparam logic [1:0] CR_EN_CLR = 2'b10;

  localparam logic [2:0] CR_CMD_RESET_RX = 3'b010;
  localparam logic [2:0] CR_CMD_RESET_TX = 3'b011;
  localparam logic [2:0] CR_CMD_CLR_OVR  = 3'b100;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/duart_rx_fifo.sv
// duart_rx_fifo: receive FIFO of RX_DEPTH bytes.
//   clk, reset (async, active-high)
//   push/din  : write; ignored when full unless a pop happens in the same cycle
//   pop/dout  : dout is the head entry; pop ignored when empty
//   flush     : empties the FIFO, takes priority over push/pop
//   count, full, empty : occupancy
module duart_rx_fifo #(
  parameter  int RX_DEPTH = 3,
  localparam int CW       = $clog2(RX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  logic [7:0]    mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RX_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(RX_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the push overwrites.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
//   i_Clock, i_Rst (async, active-high), i_Rx_Serial (idle high)
//   o_Rx_DV   : one-cycle pulse when o_Rx_Byte holds a new character
//   o_Rx_Byte : received character
module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);

  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);

  logic [1:0]  sync;
  logic [1:0]  state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic        rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      sync      <= 2'b11;
      state     <= 2'd0;
      cnt       <= '0;
      idx       <= '0;
      o_Rx_DV   <= 1'b0;
      o_Rx_Byte <= '0;
    end else begin
      sync    <= {sync[0], i_Rx_Serial};
      o_Rx_DV <= 1'b0;
      case (state)
        2'd0: begin
          cnt <= '0;
          if (!rx_s) state <= 2'd1;
        end
        2'd1: begin
          // Re-check the start bit at its centre to reject glitches.
          if (cnt == HALF_CNT) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? 2'd0 : 2'd2;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        2'd2: begin
          if (cnt == FULL_CNT) begin
            cnt            <= '0;
            o_Rx_Byte[idx] <= rx_s;
            if (idx == 3'd7) state <= 2'd3;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          if (cnt == FULL_CNT) begin
            o_Rx_DV <= 1'b1;
            state   <= 2'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter.
//   i_Clock, i_Rst (async, active-high)
//   i_Tx_DV     : start pulse, accepted only while idle
//   i_Tx_Byte   : character to send
//   o_Tx_Active : high from the cycle after i_Tx_DV until the stop bit ends
//   o_Tx_Serial : serial line, idle high
module uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial
);

  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  logic [8:0]  sh;
  logic [15:0] cnt;
  logic [3:0]  idx;

  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      sh          <= '1;
      cnt         <= '0;
      idx         <= '0;
      o_Tx_Active <= 1'b0;
      o_Tx_Serial <= 1'b1;
    end else if (!o_Tx_Active) begin
      if (i_Tx_DV) begin
        sh          <= {1'b1, i_Tx_Byte};
        cnt         <= '0;
        idx         <= '0;
        o_Tx_Active <= 1'b1;
        o_Tx_Serial <= 1'b0;
      end
    end else if (cnt == FULL_CNT) begin
      cnt <= '0;
      if (idx == 4'd9) begin
        o_Tx_Active <= 1'b0;
        o_Tx_Serial <= 1'b1;
      end else begin
        // The stop bit shifts in from the top as the data drains out.
        idx         <= idx + 4'd1;
        o_Tx_Serial <= sh[0];
        sh          <= {1'b1, sh[8:1]};
      end
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/duart_channel.sv
// duart_channel: one SCN2681-style serial channel.
//   clk, reset (async, active-high)
//   clken, enable, we, addr[1:0], di[7:0] : register access
//   dout[7:0] : read data, combinational from addr (MR, SR, CR=0, RHR)
//   rx, tx    : serial lines, idle high
//   int_rx    : RxRDY or FFULL (RX_INT_FULL), registered
//   int_tx    : TxRDY, registered
// Optional build macro DUART_CHANNEL_LOOPBACK_EN: writable MR, MR[7:6]=10
// routes tx into the receiver and holds the tx pin high.
module duart_channel
  import duart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 0,
  parameter int RX_DEPTH     = 3,
  parameter int RX_INT_FULL  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clken,
  input  logic       enable,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] di,
  output logic [7:0] dout,
  input  logic       rx,
  output logic       tx,
  output logic       int_rx,
  output logic       int_tx
);

  localparam int CW = $clog2(RX_DEPTH + 1);

  logic          bus_wr, bus_rd, cr_wr;
  logic [2:0]    cr_cmd;
  logic          rx_reset_cmd, tx_reset_cmd, clr_ovr_cmd;
  logic          rx_en, tx_en, overrun;
  logic          rx_dv, rx_line;
  logic [7:0]    rx_byte;
  logic          tx_dv, tx_active, tx_serial;
  logic [7:0]    tx_byte;
  logic          hold_full;
  logic [7:0]    hold_data;
  tx_state_t     tx_state;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          rxrdy, ffull, txrdy, txemt;
  logic [7:0]    sr;
  logic [7:0]    mr;
  logic          loopback;

  assign bus_wr       = clken & enable & we;
  assign bus_rd       = clken & enable & ~we;
  assign cr_wr        = bus_wr & (addr == ADDR_CR);
  assign cr_cmd       = di[6:4];
  assign rx_reset_cmd = cr_wr & (cr_cmd == CR_CMD_RESET_RX);
  assign tx_reset_cmd = cr_wr & (cr_cmd == CR_CMD_RESET_TX);
  assign clr_ovr_cmd  = cr_wr & (cr_cmd == CR_CMD_CLR_OVR);

`ifdef DUART_CHANNEL_LOOPBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              mr <= 8'h00;
    else if (bus_wr && (addr == ADDR_MR))   mr <= di;
  end
  assign loopback = (mr[7:6] == 2'b10);
`else
  logic unused_mr_bit;
  assign mr            = 8'h00;
  assign loopback      = 1'b0;
  assign unused_mr_bit = di[7];
`endif

  assign rx_line = loopback ? tx_serial : rx;
  assign tx      = loopback ? 1'b1 : tx_serial;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock     (clk),
    .i_Rst       (reset),
    .i_Rx_Serial (rx_line),
    .o_Rx_DV     (rx_dv),
    .o_Rx_Byte   (rx_byte)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .i_Clock     (clk),
    .i_Rst       (reset),
    .i_Tx_DV     (tx_dv),
    .i_Tx_Byte   (tx_byte),
    .o_Tx_Active (tx_active),
    .o_Tx_Serial (tx_serial)
  );

  assign fifo_push = rx_dv & rx_en;
  assign fifo_pop  = bus_rd & (addr == ADDR_RHR) & ~fifo_empty;

  duart_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (rx_reset_cmd),
    .din   (rx_byte),
    .dout  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  logic unused_count;
  assign unused_count = ^fifo_count;

  assign rxrdy = ~fifo_empty;
  assign ffull = fifo_full;
  assign txrdy = ~hold_full & tx_en;
  assign txemt = ~hold_full & (tx_state == TX_IDLE);

  always_comb begin
    sr             = 8'h00;
    sr[SR_RXRDY]   = rxrdy;
    sr[SR_FFULL]   = ffull;
    sr[SR_TXRDY]   = txrdy;
    sr[SR_TXEMT]   = txemt;
    sr[SR_OVERRUN] = overrun;
  end

  always_comb begin
    case (addr)
      ADDR_MR:  dout = mr;
      ADDR_SR:  dout = sr;
      ADDR_CR:  dout = 8'h00;
      default:  dout = fifo_head;
    endcase
  end

  // Reset commands override any enable field carried by the same write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_en   <= 1'b0;
      tx_en   <= 1'b0;
      overrun <= 1'b0;
      int_rx  <= 1'b0;
      int_tx  <= 1'b0;
    end else begin
      if (cr_wr) begin
        if (cr_cmd == CR_CMD_RESET_RX)  rx_en <= 1'b0;
        else if (di[1:0] == CR_EN_SET)  rx_en <= 1'b1;
        else if (di[1:0] == CR_EN_CLR)  rx_en <= 1'b0;
        if (cr_cmd == CR_CMD_RESET_TX)  tx_en <= 1'b0;
        else if (di[3:2] == CR_EN_SET)  tx_en <= 1'b1;
        else if (di[3:2] == CR_EN_CLR)  tx_en <= 1'b0;
      end
      if (fifo_push && fifo_full && !fifo_pop) overrun <= 1'b1;
      else if (clr_ovr_cmd)                    overrun <= 1'b0;
      int_rx <= (RX_INT_FULL != 0) ? ffull : rxrdy;
      int_tx <= txrdy;
    end
  end

  // tx_dv is registered on entry to TX_START so it is high exactly there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      tx_dv     <= 1'b0;
      tx_byte   <= 8'h00;
    end else begin
      tx_dv <= 1'b0;
      if (bus_wr && (addr == ADDR_RHR) && txrdy) begin
        hold_full <= 1'b1;
        hold_data <= di;
      end
      case (tx_state)
        TX_IDLE: begin
          if (hold_full && !tx_reset_cmd) begin
            tx_state <= TX_START;
            tx_dv    <= 1'b1;
            tx_byte  <= hold_data;
          end
        end
        TX_START: begin
          hold_full <= 1'b0;
          tx_state  <= TX_WAIT;
        end
        TX_WAIT: if (tx_active)  tx_state <= TX_BUSY;
        default: if (!tx_active) tx_state <= TX_IDLE;
      endcase
      if (tx_reset_cmd) hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_duart_channel.sv
// tb_duart_channel: directed bench for duart_channel with RX_DEPTH = 3,
// RX_INT_FULL = 0 and 8 clocks per bit.
module tb_duart_channel;

  localparam int CPB = 8;
  localparam logic [1:0] A_MR  = 2'd0;
  localparam logic [1:0] A_SR  = 2'd1;
  localparam logic [1:0] A_CR  = 2'd2;
  localparam logic [1:0] A_RHR = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clken = 1'b0;
  logic       enable = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] di = 8'h00;
  logic [7:0] dout;
  logic       rx = 1'b1;
  logic       tx;
  logic       int_rx;
  logic       int_tx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  duart_channel #(.CLKS_PER_BIT(CPB), .RX_DEPTH(3), .RX_INT_FULL(0)) dut (
    .clk    (clk),
    .reset  (reset),
    .clken  (clken),
    .enable (enable),
    .we     (we),
    .addr   (addr),
    .di     (di),
    .dout   (dout),
    .rx     (rx),
    .tx     (tx),
    .int_rx (int_rx),
    .int_tx (int_tx)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    clken = 1'b1; enable = 1'b1; we = 1'b1; addr = a; di = d;
    @(negedge clk);
    clken = 1'b0; enable = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    clken = 1'b1; enable = 1'b1; we = 1'b0; addr = a;
    #1 d = dout;
    @(negedge clk);
    clken = 1'b0; enable = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB + 4) @(negedge clk);
  endtask

  task automatic capture_tx(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (CPB / 2) @(negedge clk);
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_txrdy(output logic seen);
    logic [7:0] r;
    seen = 1'b0;
    for (int t = 0; t < 300; t++) begin
      bus_read(A_SR, r);
      if (r[2]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r, b0, b1;
    logic       ok0, ok1, seen;
    int         hi_viol;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    addr = A_SR;
    #1;
    check_val("rst_sr", dout, 8'h08);
    check_val("rst_tx", tx, 1'b1);
    check_val("rst_int_rx", int_rx, 1'b0);
    check_val("rst_int_tx", int_tx, 1'b0);

    // Reset in the middle of a character
    bus_write(A_CR, 8'h04);
    bus_write(A_RHR, 8'h00);
    repeat (20) @(negedge clk);
    check_val("mid_tx_low", tx, 1'b0);
    #2 reset = 1'b1;
    #1 check_val("midrst_tx", tx, 1'b1);
    addr = A_SR;
    #1 check_val("midrst_sr", dout, 8'h08);
    check_val("midrst_ints", {6'd0, int_rx, int_tx}, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Double-buffered transmit
    bus_write(A_CR, 8'h05);
    fork
      begin
        capture_tx(b0, ok0);
        capture_tx(b1, ok1);
      end
      begin
        bus_write(A_RHR, 8'h55);
        bus_read(A_SR, r);
        check_val("txrdy_drop1", r[2], 1'b0);
        wait_txrdy(seen);
        check_val("txrdy_back1", seen, 1'b1);
        bus_write(A_RHR, 8'hAA);
        bus_read(A_SR, r);
        check_val("txrdy_drop2", r[2], 1'b0);
      end
    join
    check_val("tx_frame1_ok", ok0, 1'b1);
    check_val("tx_byte1", b0, 8'h55);
    check_val("tx_frame2_ok", ok1, 1'b1);
    check_val("tx_byte2", b1, 8'hAA);
    repeat (12) @(negedge clk);
    bus_read(A_SR, r);
    check_val("tx_done_sr", r, 8'h0C);
    check_val("tx_done_int_tx", int_tx, 1'b1);

    // Fill past depth: fourth byte overruns
    send_byte(8'h01);
    check_val("int_rx_rxrdy", int_rx, 1'b1);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    bus_read(A_SR, r);
    check_val("ovr_sr", r, 8'h1F);
    bus_read(A_RHR, r); check_val("rhr_0", r, 8'h01);
    bus_read(A_RHR, r); check_val("rhr_1", r, 8'h02);
    bus_read(A_RHR, r); check_val("rhr_2", r, 8'h03);
    bus_read(A_SR, r);
    check_val("drained_sr", r, 8'h1C);
    bus_write(A_CR, 8'h40);
    bus_read(A_SR, r);
    check_val("ovr_clr_sr", r, 8'h0C);
    check_val("int_rx_clear", int_rx, 1'b0);

    // Pop on the exact push cycle while full
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    fork
      send_byte(8'h44);
      begin
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (dut.rx_dv) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          clken = 1'b1; enable = 1'b1; we = 1'b0; addr = A_RHR;
          #1 r = dout;
          @(negedge clk);
          clken = 1'b0; enable = 1'b0;
        end else begin
          r = 8'hxx;
        end
        check_val("dv_seen", seen, 1'b1);
        check_val("same_cycle_pop", r, 8'h11);
      end
    join
    bus_read(A_SR, r);
    check_val("same_cycle_sr", r, 8'h0F);
    bus_read(A_RHR, r); check_val("tail_0", r, 8'h22);
    bus_read(A_RHR, r); check_val("tail_1", r, 8'h33);
    bus_read(A_RHR, r); check_val("tail_2", r, 8'h44);
    bus_read(A_SR, r);
    check_val("tail_empty_sr", r, 8'h0C);

    // Reset receiver keeps overrun, blocks further bytes
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h99);
    send_byte(8'h66);
    bus_read(A_SR, r);
    check_val("rxrst_pre_sr", r, 8'h1F);
    bus_write(A_CR, 8'h20);
    bus_read(A_SR, r);
    check_val("rxrst_sr", r, 8'h1C);
    bus_write(A_CR, 8'h21);
    send_byte(8'h77);
    bus_read(A_SR, r);
    check_val("rxrst_ignored_sr", r, 8'h1C);
    bus_write(A_CR, 8'h40);
    bus_read(A_SR, r);
    check_val("rxrst_ovr_clr", r, 8'h0C);

    // THR write dropped while TxRDY is low
    bus_write(A_CR, 8'h08);
    bus_read(A_SR, r);
    check_val("txdis_sr", r, 8'h08);
    bus_write(A_RHR, 8'h77);
    repeat (5) @(negedge clk);
    bus_read(A_SR, r);
    check_val("thr_drop_sr", r, 8'h08);
    check_val("thr_drop_tx", tx, 1'b1);
    check_val("thr_drop_int_tx", int_tx, 1'b0);
    bus_read(A_CR, r);
    check_val("cr_read", r, 8'h00);

`ifdef DUART_CHANNEL_LOOPBACK_EN
    bus_write(A_CR, 8'h05);
    bus_write(A_MR, 8'h80);
    bus_read(A_MR, r);
    check_val("mr_read", r, 8'h80);
    bus_write(A_RHR, 8'h3C);
    hi_viol = 0;
    repeat (130) begin
      @(negedge clk);
      if (tx !== 1'b1) hi_viol++;
    end
    check_val("loop_tx_high", 8'(hi_viol), 8'h00);
    bus_read(A_RHR, r);
    check_val("loop_rhr", r, 8'h3C);
`else
    hi_viol = 0;
    bus_write(A_MR, 8'h80);
    bus_read(A_MR, r);
    check_val("mr_read", r, 8'h00);
    check_val("mr_no_effect_tx", tx, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
